// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the 6502 interrupt/reset entry sequencer.
package int_sequencer_pkg;

  typedef enum logic [2:0] {
    INT_SRC_NONE  = 3'd0,
    INT_SRC_RESET = 3'd1,
    INT_SRC_NMI   = 3'd2,
    INT_SRC_IRQ   = 3'd3,
    INT_SRC_BRK   = 3'd4
  } int_src_e;

  typedef enum logic [2:0] {
    INT_IDLE     = 3'd0,
    INT_PUSH_PCH = 3'd1,
    INT_PUSH_PCL = 3'd2,
    INT_PUSH_P   = 3'd3,
    INT_VEC_LO   = 3'd4,
    INT_VEC_HI   = 3'd5,
    INT_LOAD     = 3'd6
  } int_state_e;

  localparam int STATUS_B_BIT = 4;
  localparam int STATUS_U_BIT = 5;

  localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;
  localparam logic [15:0] DEF_STACK_BASE   = 16'h0100;

  // BRK shares the IRQ vector; NONE never reaches a vector state.
  function automatic logic [15:0] src_vector(input int_src_e s,
                                             input logic [15:0] nmi_vec,
                                             input logic [15:0] rst_vec,
                                             input logic [15:0] irq_vec);
    case (s)
      INT_SRC_RESET: src_vector = rst_vec;
      INT_SRC_NMI:   src_vector = nmi_vec;
      default:       src_vector = irq_vec;
    endcase
  endfunction

endpackage

// File: rtl/int_edge_detect.sv
// NMI falling-edge detector: one sample flop plus a pending latch.
module int_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic clr,
  output logic pend
);

  logic nmi_n_q;

  // A new edge wins over a clear in the same cycle so no NMI is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_n_q <= 1'b1;
      pend    <= 1'b0;
    end else begin
      nmi_n_q <= nmi_n;
      if (nmi_n_q && !nmi_n) pend <= 1'b1;
      else if (clr)          pend <= 1'b0;
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Reset/NMI/BRK/IRQ entry sequencer: pushes PCH, PCL, P, fetches the vector, loads PC.
//
//   state    | meaning
//   IDLE     | core runs; arbitrate at instruction boundaries
//   PUSH_PCH | write PC high byte to stack
//   PUSH_PCL | write PC low byte to stack
//   PUSH_P   | write status to stack
//   VEC_LO   | read vector low byte
//   VEC_HI   | read vector high byte
//   LOAD     | load PC, set I
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter logic [15:0] NMI_VECTOR   = DEF_NMI_VECTOR,
  parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
  parameter logic [15:0] STACK_BASE   = DEF_STACK_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        i_flag,
  input  logic        instruction_done,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  status_in,
  input  logic [7:0]  d_in,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic [7:0]  d_out,
  output logic        mem_we,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_out,
  output logic        set_i,
  output logic [2:0]  src
);

  int_state_e state_q, state_d;
  int_src_e   src_q, src_d;
  logic       rst_pend_q, rst_pend_d;
  logic [7:0] vec_lo_q, vec_hi_q;
  logic       nmi_pend, nmi_clr;

  int_edge_detect u_nmi_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .nmi_n   (nmi_n),
    .clr     (nmi_clr),
    .pend    (nmi_pend)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INT_IDLE;
      src_q      <= INT_SRC_NONE;
      rst_pend_q <= 1'b1;
      vec_lo_q   <= 8'h00;
      vec_hi_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      rst_pend_q <= rst_pend_d;
      if (state_q == INT_VEC_LO) vec_lo_q <= d_in;
      if (state_q == INT_VEC_HI) vec_hi_q <= d_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    rst_pend_d = rst_pend_q;
    nmi_clr    = 1'b0;
    case (state_q)
      INT_IDLE: begin
        if (rst_pend_q) begin
          state_d    = INT_PUSH_PCH;
          src_d      = INT_SRC_RESET;
          rst_pend_d = 1'b0;
        end else if (instruction_done) begin
          if (nmi_pend) begin
            state_d = INT_PUSH_PCH;
            src_d   = INT_SRC_NMI;
            nmi_clr = 1'b1;
          end else if (brk_req) begin
            state_d = INT_PUSH_PCH;
            src_d   = INT_SRC_BRK;
          end else if (!irq_n && !i_flag) begin
            state_d = INT_PUSH_PCH;
            src_d   = INT_SRC_IRQ;
          end
        end
      end
      INT_PUSH_PCH: state_d = INT_PUSH_PCL;
      INT_PUSH_PCL: state_d = INT_PUSH_P;
      INT_PUSH_P: begin
        state_d = INT_VEC_LO;
        // Late NMI steals the vector fetch; P already went out with the original B bit.
        if (nmi_pend && (src_q == INT_SRC_IRQ || src_q == INT_SRC_BRK)) begin
          src_d   = INT_SRC_NMI;
          nmi_clr = 1'b1;
        end
      end
      INT_VEC_LO: state_d = INT_VEC_HI;
      INT_VEC_HI: state_d = INT_LOAD;
      INT_LOAD: begin
        state_d = INT_IDLE;
        src_d   = INT_SRC_NONE;
      end
      default: begin
        state_d = INT_IDLE;
        src_d   = INT_SRC_NONE;
      end
    endcase
  end

  logic [15:0] vec_base;
  logic [15:0] stack_addr;
  logic [7:0]  p_push;

  always_comb begin
    vec_base   = src_vector(src_q, NMI_VECTOR, RESET_VECTOR, IRQ_VECTOR);
    stack_addr = STACK_BASE + {8'h00, sp_in};
    p_push     = status_in;
    p_push[STATUS_U_BIT] = 1'b1;
    p_push[STATUS_B_BIT] = (src_q == INT_SRC_BRK);

    addr_out = 16'h0000;
    d_out    = 8'h00;
    mem_we   = 1'b0;
    sp_dec   = 1'b0;
    pc_load  = 1'b0;
    pc_out   = 16'h0000;
    set_i    = 1'b0;
    case (state_q)
      INT_PUSH_PCH, INT_PUSH_PCL, INT_PUSH_P: begin
        addr_out = stack_addr;
        sp_dec   = 1'b1;
        mem_we   = (src_q != INT_SRC_RESET);
        case (state_q)
          INT_PUSH_PCH: d_out = pc_in[15:8];
          INT_PUSH_PCL: d_out = pc_in[7:0];
          default:      d_out = p_push;
        endcase
      end
      INT_VEC_LO: addr_out = vec_base;
      INT_VEC_HI: addr_out = vec_base + 16'd1;
      INT_LOAD: begin
        pc_out  = {vec_hi_q, vec_lo_q};
        pc_load = 1'b1;
        set_i   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != INT_IDLE);
  assign src  = src_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: expected bus cycles queued per request, compared per busy cycle.
module tb_int_sequencer;

  localparam logic [2:0] S_NONE = 3'd0, S_RESET = 3'd1, S_NMI = 3'd2, S_IRQ = 3'd3, S_BRK = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        nmi_n = 1'b1;
  logic        irq_n = 1'b1;
  logic        brk_req = 1'b0;
  logic        i_flag = 1'b1;
  logic        instruction_done = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  sp_in = 8'hFD;
  logic [7:0]  status_in = 8'h00;
  logic [7:0]  d_in;
  logic        busy;
  logic [15:0] addr_out;
  logic [7:0]  d_out;
  logic        mem_we;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_out;
  logic        set_i;
  logic [2:0]  src;

  logic [7:0] mem [0:65535];
  assign d_in = mem[addr_out];

  // {we, sp_dec, pc_load, set_i, src, addr, d_out, pc_out}
  typedef logic [46:0] cyc_t;
  cyc_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  int_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .nmi_n            (nmi_n),
    .irq_n            (irq_n),
    .brk_req          (brk_req),
    .i_flag           (i_flag),
    .instruction_done (instruction_done),
    .pc_in            (pc_in),
    .sp_in            (sp_in),
    .status_in        (status_in),
    .d_in             (d_in),
    .busy             (busy),
    .addr_out         (addr_out),
    .d_out            (d_out),
    .mem_we           (mem_we),
    .sp_dec           (sp_dec),
    .pc_load          (pc_load),
    .pc_out           (pc_out),
    .set_i            (set_i),
    .src              (src)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] pc,
                          input logic [7:0] sp, input logic [7:0] p,
                          input logic [15:0] vec, input logic [15:0] target);
    logic       we;
    logic [7:0] s1, s2, pd;
    we = (sa != S_RESET);
    s1 = sp - 8'd1;
    s2 = sp - 8'd2;
    pd = (p & 8'hEF) | 8'h20 | ((sa == S_BRK) ? 8'h10 : 8'h00);
    exp_q.push_back({we, 1'b1, 1'b0, 1'b0, sa, 8'h01, sp, pc[15:8], 16'h0000});
    exp_q.push_back({we, 1'b1, 1'b0, 1'b0, sa, 8'h01, s1, pc[7:0], 16'h0000});
    exp_q.push_back({we, 1'b1, 1'b0, 1'b0, sa, 8'h01, s2, pd, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, sb, vec, 8'h00, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, sb, vec + 16'd1, 8'h00, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, sb, 16'h0000, 8'h00, target});
  endtask

  // Runs the bus side of a sequence; nmi_at/done_at inject stimulus at a given cycle index.
  task automatic watch(input int nmi_at, input int done_at);
    int         c;
    logic       b_s, we_s, spd_s;
    logic [15:0] a_s;
    logic [7:0] d_s;
    cyc_t       got, exp;
    c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      @(negedge clk);
      if (c == nmi_at)  nmi_n = 1'b0;
      if (c == done_at) instruction_done = 1'b1;
      c++;
      b_s = busy; we_s = mem_we; spd_s = sp_dec; a_s = addr_out; d_s = d_out;
      if (b_s) begin
        got = {mem_we, sp_dec, pc_load, set_i, src, addr_out, d_out, pc_out};
        exp = exp_q.pop_front();
        check_val("cycle", 64'(got), 64'(exp));
      end
      @(posedge clk);
      #1;
      instruction_done = 1'b0;
      if (b_s && we_s) mem[a_s] = d_s;
      if (b_s && spd_s) sp_in = sp_in - 8'd1;
    end
    if (exp_q.size() != 0) begin
      check_val("seq_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
    check_val("idle_after", 64'(busy), 64'd0);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    instruction_done = 1'b1;
    @(posedge clk);
    #1;
    instruction_done = 1'b0;
  endtask

  initial begin
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'hA0;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h90;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_busy",  64'(busy),     64'd0);
    check_val("rst_we",    64'(mem_we),   64'd0);
    check_val("rst_spdec", 64'(sp_dec),   64'd0);
    check_val("rst_pcld",  64'(pc_load),  64'd0);
    check_val("rst_seti",  64'(set_i),    64'd0);
    check_val("rst_src",   64'(src),      64'(S_NONE));
    check_val("rst_addr",  64'(addr_out), 64'd0);
    check_val("rst_pcout", 64'(pc_out),   64'd0);

    // Reset sequence: dummy pushes, vector FFFC
    sp_in = 8'hFD; pc_in = 16'h0000; status_in = 8'h00;
    push_seq(S_RESET, S_RESET, pc_in, 8'hFD, status_in, 16'hFFFC, 16'h8000);
    reset_n = 1'b1;
    watch(-1, -1);
    check_val("rst_sp_after", 64'(sp_in), 64'hFA);

    // Masked IRQ then unmasked
    sp_in = 8'hFD; pc_in = 16'h8123; status_in = 8'h20; irq_n = 1'b0; i_flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse_done();
      @(negedge clk);
      check_val("irq_masked", 64'(busy), 64'd0);
    end
    i_flag = 1'b0;
    push_seq(S_IRQ, S_IRQ, pc_in, 8'hFD, status_in, 16'hFFFE, 16'h9000);
    pulse_done();
    watch(-1, -1);
    irq_n = 1'b1; i_flag = 1'b1;
    check_val("irq_mem_1fd", 64'(mem[16'h01FD]), 64'h81);
    check_val("irq_mem_1fc", 64'(mem[16'h01FC]), 64'h23);
    check_val("irq_mem_1fb", 64'(mem[16'h01FB]), 64'h20);

    // BRK (I flag set does not mask it)
    sp_in = 8'hFD; pc_in = 16'hC002; status_in = 8'h01; brk_req = 1'b1;
    push_seq(S_BRK, S_BRK, pc_in, 8'hFD, status_in, 16'hFFFE, 16'h9000);
    pulse_done();
    brk_req = 1'b0;
    watch(-1, -1);
    check_val("brk_mem_p", 64'(mem[16'h01FB]), 64'h31);

    // NMI beats IRQ; SP wraps within page 1; done in LOAD is ignored
    sp_in = 8'h01; pc_in = 16'h4567; status_in = 8'h04; irq_n = 1'b0; i_flag = 1'b0;
    @(negedge clk); nmi_n = 1'b0;
    @(negedge clk);
    check_val("nmi_wait_boundary", 64'(busy), 64'd0);
    push_seq(S_NMI, S_NMI, pc_in, 8'h01, status_in, 16'hFFFA, 16'hA000);
    pulse_done();
    watch(-1, 5);
    check_val("wrap_mem_1ff", 64'(mem[16'h01FF]), 64'h24);
    irq_n = 1'b1; nmi_n = 1'b1;
    repeat (2) @(negedge clk);

    // NMI hijack of an accepted IRQ
    sp_in = 8'hFD; pc_in = 16'h1234; status_in = 8'h20; irq_n = 1'b0; i_flag = 1'b0;
    push_seq(S_IRQ, S_NMI, pc_in, 8'hFD, status_in, 16'hFFFA, 16'hA000);
    pulse_done();
    irq_n = 1'b1;
    watch(1, -1);
    check_val("hijack_p_b0", 64'(mem[16'h01FB]), 64'h20);
    pulse_done();
    @(negedge clk);
    check_val("hijack_pend_clr", 64'(busy), 64'd0);
    nmi_n = 1'b1;

    // Reset abort during VEC_HI, then a clean reset entry
    sp_in = 8'hFD; pc_in = 16'hBEEF; irq_n = 1'b0; i_flag = 1'b0;
    pulse_done();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check_val("abort_addr", 64'(addr_out), 64'hFFFF);
        reset_n = 1'b0;
        #1;
      end
      check_val("abort_pcload", 64'(pc_load), 64'd0);
    end
    check_val("abort_busy", 64'(busy), 64'd0);
    irq_n = 1'b1; i_flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abort_hold_pcload", 64'(pc_load), 64'd0);
    end
    sp_in = 8'hFD; pc_in = 16'h0000; status_in = 8'h00;
    push_seq(S_RESET, S_RESET, pc_in, 8'hFD, status_in, 16'hFFFC, 16'h8000);
    reset_n = 1'b1;
    watch(-1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
